// File: rtl/fib_rec_pkg.sv
// Shared constants for the single-digit BCD Fibonacci recogniser.
package fib_rec_pkg;

    // Bit i is set when digit i is a Fibonacci number and a valid BCD digit.
    localparam logic [15:0] FIB_MASK = 16'b0000_0001_0010_1111;
    localparam int          BCD_MAX  = 9;

endpackage

// File: rtl/fib_rec_core.sv
// Combinational decoder: flags Fibonacci digits and out-of-range BCD codes.
module fib_rec_core
    import fib_rec_pkg::*;
(
    input  logic [3:0] BCD_in,
    output logic       y,
    output logic       bcd_err
);

    always_comb begin
        bcd_err = (BCD_in > 4'(BCD_MAX));
        // Mask bits 10-15 are zero, but gate anyway so y and bcd_err are never both set.
        y       = FIB_MASK[BCD_in] & ~bcd_err;
    end

endmodule

// File: rtl/fib_rec.sv
// Fibonacci digit recogniser with a registered copy of y and a saturating hit counter.
module fib_rec
    import fib_rec_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       BCD_in,
    output logic             y,
    output logic             bcd_err,
    output logic             y_q,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             y_d;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    fib_rec_core u_core (
        .BCD_in  (BCD_in),
        .y       (y),
        .bcd_err (bcd_err)
    );

    always_comb begin
        y_d   = y;
        cnt_d = cnt_q;
        if (y && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Synchronous active-low reset takes priority over any increment on the same edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            y_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            y_q   <= y_d;
            cnt_q <= cnt_d;
        end
    end

    assign hit_cnt = cnt_q;

endmodule

// File: tb/tb_fib_rec.sv
// Directed self-checking bench for fib_rec (default width and a 2-bit counter instance).
module tb_fib_rec;

    logic       clk;
    logic       reset;
    logic [3:0] BCD_in;
    logic       y;
    logic       bcd_err;
    logic       y_q;
    logic [7:0] hit_cnt;
    logic       y_s;
    logic       bcd_err_s;
    logic       y_q_s;
    logic [1:0] hit_cnt_s;

    int n_tests = 0;
    int n_fail  = 0;

    fib_rec u_dut (
        .clk     (clk),
        .reset   (reset),
        .BCD_in  (BCD_in),
        .y       (y),
        .bcd_err (bcd_err),
        .y_q     (y_q),
        .hit_cnt (hit_cnt)
    );

    fib_rec #(.CNT_W(2)) u_dut_small (
        .clk     (clk),
        .reset   (reset),
        .BCD_in  (BCD_in),
        .y       (y_s),
        .bcd_err (bcd_err_s),
        .y_q     (y_q_s),
        .hit_cnt (hit_cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Hold BCD_in at v for n rising edges; returns just after the last edge.
    task automatic run(input logic [3:0] v, input int n);
        BCD_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        run(4'd4, 1);
        reset = 1'b1;
    endtask

    // Hand-written digit tables: expected y and bcd_err for 0..15.
    logic [0:15] fib_tab = 16'b1111_0100_1000_0000;
    logic [0:15] err_tab = 16'b0000_0000_0011_1111;
    logic [3:0]  lat_seq [3] = '{4'd2, 4'd4, 4'd8};
    logic        lat_exp [3] = '{1'b1, 1'b0, 1'b1};

    initial begin
        reset  = 1'b0;
        BCD_in = 4'd3;

        // Reset held for two edges with a Fibonacci digit applied.
        run(4'd3, 2);
        @(negedge clk);
        check("rst_y", 32'(y), 32'd1);
        check("rst_y_q", 32'(y_q), 32'd0);
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check("rst_hit_cnt_small", 32'(hit_cnt_s), 32'd0);
        reset = 1'b1;
        run(4'd3, 1);
        @(negedge clk);
        check("rel_y_q", 32'(y_q), 32'd1);
        check("rel_hit_cnt", 32'(hit_cnt), 32'd1);

        // Exhaustive combinational sweep, driven after posedge, checked on negedge.
        for (int v = 0; v < 16; v++) begin
            @(posedge clk);
            #1;
            BCD_in = 4'(v);
            @(negedge clk);
            check($sformatf("y[%0d]", v), 32'(y), 32'(fib_tab[v]));
            check($sformatf("bcd_err[%0d]", v), 32'(bcd_err), 32'(err_tab[v]));
        end

        // One-cycle registered latency.
        for (int i = 0; i < 3; i++) begin
            run(lat_seq[i], 1);
            @(negedge clk);
            check($sformatf("lat_y_q[%0d]", i), 32'(y_q), 32'(lat_exp[i]));
        end

        // Counter counts hits and holds on a non-Fibonacci digit.
        reset_pulse();
        run(4'd0, 10);
        @(negedge clk);
        check("cnt_after_0s", 32'(hit_cnt), 32'd10);
        check("cnt_small_sat", 32'(hit_cnt_s), 32'd3);
        run(4'd7, 5);
        @(negedge clk);
        check("cnt_after_7s", 32'(hit_cnt), 32'd10);
        check("y_q_after_7s", 32'(y_q), 32'd0);

        // Holds on invalid BCD 13 even though 13 is a Fibonacci number.
        run(4'd13, 3);
        @(negedge clk);
        check("cnt_after_13", 32'(hit_cnt), 32'd10);

        // Saturation of the 2-bit counter.
        reset_pulse();
        run(4'd1, 3);
        @(negedge clk);
        check("sat_small_3", 32'(hit_cnt_s), 32'd3);
        run(4'd1, 3);
        @(negedge clk);
        check("sat_small_6", 32'(hit_cnt_s), 32'd3);
        check("sat_wide_6", 32'(hit_cnt), 32'd6);

        // Saturation of the default 8-bit counter.
        run(4'd5, 254);
        @(negedge clk);
        check("sat_wide_255", 32'(hit_cnt), 32'd255);
        run(4'd5, 2);
        @(negedge clk);
        check("sat_wide_hold", 32'(hit_cnt), 32'd255);

        // Mid-run reset beats the increment.
        reset_pulse();
        run(4'd5, 5);
        @(negedge clk);
        check("mid_cnt_5", 32'(hit_cnt), 32'd5);
        reset = 1'b0;
        run(4'd5, 1);
        @(negedge clk);
        check("mid_rst_cnt", 32'(hit_cnt), 32'd0);
        check("mid_rst_y_q", 32'(y_q), 32'd0);
        check("mid_rst_y", 32'(y), 32'd1);
        reset = 1'b1;
        run(4'd5, 1);
        @(negedge clk);
        check("mid_resume_cnt", 32'(hit_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
